time_entry: RTL and testbench



---
 rtl/time_entry_pkg.sv | 44 ++++
 rtl/time_entry_if.sv | 37 +++
 rtl/time_entry_btn_debounce.sv | 59 +++++
 rtl/time_entry.sv | 187 ++++++++++++++++++
 tb/tb_time_entry.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/time_entry_pkg.sv
// ---------------------------------------------------------------------------
// time_entry_pkg
// Shared types and constants for the time/alarm entry controller.
//   state_t      : entry FSM state encoding
//   *_MAX        : highest legal value of each BCD digit
//   CUR_*        : cursor encoding of the digit under edit
//   wrap_inc4    : increment a 4-bit digit, wrapping to 0 past a limit
// ---------------------------------------------------------------------------
package time_entry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EDIT_H1 = 3'd1,
    ST_EDIT_H0 = 3'd2,
    ST_EDIT_M1 = 3'd3,
    ST_EDIT_M0 = 3'd4,
    ST_LOAD    = 3'd5
  } state_t;

  localparam logic [1:0] H1_MAX       = 2'd2;
  localparam logic [3:0] H0_MAX       = 4'd9;
  localparam logic [3:0] H0_MAX_AT_20 = 4'd3;
  localparam logic [2:0] M1_MAX       = 3'd5;
  localparam logic [3:0] M0_MAX       = 4'd9;

  localparam logic [1:0] CUR_H1 = 2'd0;
  localparam logic [1:0] CUR_H0 = 2'd1;
  localparam logic [1:0] CUR_M1 = 2'd2;
  localparam logic [1:0] CUR_M0 = 2'd3;

  // Values at or above the limit wrap to 0, so an out-of-range digit
  // always recovers on the next increment.
  function automatic logic [3:0] wrap_inc4(input logic [3:0] val,
                                           input logic [3:0] lim);
    logic [3:0] res;
    if (val >= lim) begin
      res = 4'd0;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/time_entry_if.sv
// ---------------------------------------------------------------------------
// time_entry_if
// Bundle between the board buttons, the entry controller and the clock.
//   btn_mode/btn_next/btn_inc/btn_set : raw active-high push-buttons
//   H1/H0/M1/M0                       : BCD digits being entered
//   load_time/load_alarm              : stretched load strobes
//   editing/cursor/target             : entry status for display
// master: the entry controller (drives digits and strobes)
// slave : board/clock side (drives buttons, consumes digits)
// ---------------------------------------------------------------------------
interface time_entry_if;
  import time_entry_pkg::*;

  logic       btn_mode;
  logic       btn_next;
  logic       btn_inc;
  logic       btn_set;
  logic [1:0] H1;
  logic [3:0] H0;
  logic [2:0] M1;
  logic [3:0] M0;
  logic       load_time;
  logic       load_alarm;
  logic       editing;
  logic [1:0] cursor;
  logic       target;

  modport master (
    input  btn_mode, btn_next, btn_inc, btn_set,
    output H1, H0, M1, M0, load_time, load_alarm, editing, cursor, target
  );

  modport slave (
    output btn_mode, btn_next, btn_inc, btn_set,
    input  H1, H0, M1, M0, load_time, load_alarm, editing, cursor, target
  );
endinterface

// File: rtl/time_entry_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronizes one raw button and accepts a new level only after it has
// been stable for DEBOUNCE_CYCLES clk cycles.
//   clk, reset_n : clock, asynchronous active-low reset
//   raw          : asynchronous button input
//   level        : debounced level
//   press        : one-cycle pulse on an accepted 0->1 transition
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;
  logic          press_r;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], raw};
    end
  end

  // Stability counter: measures how long the synced input has differed from
  // the accepted level; any return to the accepted level restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else if (sync_r[1] == level_r) begin
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else if ((cnt_r + CW'(1)) == CW'(DEBOUNCE_CYCLES)) begin
      cnt_r   <= '0;
      level_r <= sync_r[1];
      press_r <= sync_r[1];
    end else begin
      cnt_r   <= cnt_r + CW'(1);
      press_r <= 1'b0;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/time_entry.sv
// ---------------------------------------------------------------------------
// time_entry
// Button-driven HH:MM entry controller feeding the clock's digit/load inputs.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus (master) : buttons in; H1/H0/M1/M0, load_time, load_alarm,
//                  editing, cursor, target out (all registered)
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles needed to accept a button change
//   LOAD_CYCLES     : width of the load strobe in clk cycles
// ---------------------------------------------------------------------------
module time_entry
  import time_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOAD_CYCLES     = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  time_entry_if.master   bus
);

  localparam int LW = $clog2(LOAD_CYCLES + 1);

  logic [3:0]    raw_s;
  logic [3:0]    press_s;
  logic [3:0]    unused_level_s;

  logic          ev_set_s;
  logic          ev_mode_s;
  logic          ev_next_s;
  logic          ev_inc_s;

  logic [1:0]    h1_inc_s;
  logic [3:0]    h0_lim_s;
  logic [3:0]    h0_inc_s;
  logic [2:0]    m1_inc_s;
  logic [3:0]    m0_inc_s;
  state_t        state_nxt_s;

  state_t        state_r;
  logic [1:0]    h1_r;
  logic [3:0]    h0_r;
  logic [2:0]    m1_r;
  logic [3:0]    m0_r;
  logic          load_time_r;
  logic          load_alarm_r;
  logic          editing_r;
  logic [1:0]    cursor_r;
  logic          target_r;
  logic [LW-1:0] load_cnt_r;

  // Index order: 0=mode, 1=next, 2=inc, 3=set.
  assign raw_s = {bus.btn_set, bus.btn_inc, bus.btn_next, bus.btn_mode};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw_s[i]),
      .level   (unused_level_s[i]),
      .press   (press_s[i])
    );
  end

  // Event priority set > mode > next > inc; losers are dropped.
  always_comb begin
    ev_set_s  = press_s[3];
    ev_mode_s = press_s[0] & ~press_s[3];
    ev_next_s = press_s[1] & ~press_s[0] & ~press_s[3];
    ev_inc_s  = press_s[2] & ~press_s[1] & ~press_s[0] & ~press_s[3];
  end

  // Wrapped increment of each digit and the cursor-advance target state.
  always_comb begin
    if (h1_r >= H1_MAX) begin
      h1_inc_s = 2'd0;
    end else begin
      h1_inc_s = h1_r + 2'd1;
    end
    if (m1_r >= M1_MAX) begin
      m1_inc_s = 3'd0;
    end else begin
      m1_inc_s = m1_r + 3'd1;
    end
    h0_lim_s = (h1_r == H1_MAX) ? H0_MAX_AT_20 : H0_MAX;
    h0_inc_s = wrap_inc4(h0_r, h0_lim_s);
    m0_inc_s = wrap_inc4(m0_r, M0_MAX);
    case (state_r)
      ST_EDIT_H1: state_nxt_s = ST_EDIT_H0;
      ST_EDIT_H0: state_nxt_s = ST_EDIT_M1;
      ST_EDIT_M1: state_nxt_s = ST_EDIT_M0;
      ST_EDIT_M0: state_nxt_s = ST_EDIT_H1;
      default:    state_nxt_s = ST_EDIT_H1;
    endcase
  end

  // Entry FSM with digit registers, load stretcher and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      h1_r         <= 2'd0;
      h0_r         <= 4'd0;
      m1_r         <= 3'd0;
      m0_r         <= 4'd0;
      load_time_r  <= 1'b0;
      load_alarm_r <= 1'b0;
      editing_r    <= 1'b0;
      cursor_r     <= CUR_H1;
      target_r     <= 1'b0;
      load_cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          load_time_r  <= 1'b0;
          load_alarm_r <= 1'b0;
          if (ev_mode_s) begin
            state_r   <= ST_EDIT_H1;
            editing_r <= 1'b1;
            cursor_r  <= CUR_H1;
            target_r  <= 1'b0;
          end
        end
        ST_EDIT_H1, ST_EDIT_H0, ST_EDIT_M1, ST_EDIT_M0: begin
          if (ev_set_s) begin
            state_r    <= ST_LOAD;
            editing_r  <= 1'b0;
            cursor_r   <= CUR_H1;
            load_cnt_r <= '0;
          end else if (ev_mode_s) begin
            target_r <= ~target_r;
          end else if (ev_next_s) begin
            state_r  <= state_nxt_s;
            cursor_r <= cursor_r + 2'd1;
          end else if (ev_inc_s) begin
            case (state_r)
              ST_EDIT_H1: begin
                h1_r <= h1_inc_s;
                // Entering the 20s: pull H0 back into 0-3 in the same cycle.
                if ((h1_inc_s == H1_MAX) && (h0_r > H0_MAX_AT_20)) begin
                  h0_r <= H0_MAX_AT_20;
                end
              end
              ST_EDIT_H0: h0_r <= h0_inc_s;
              ST_EDIT_M1: m1_r <= m1_inc_s;
              ST_EDIT_M0: m0_r <= m0_inc_s;
              default:    h1_r <= h1_r;
            endcase
          end
        end
        ST_LOAD: begin
          // Strobe starts the cycle after entry and lasts LOAD_CYCLES cycles.
          if (load_cnt_r < LW'(LOAD_CYCLES)) begin
            load_cnt_r   <= load_cnt_r + LW'(1);
            load_time_r  <= ~target_r;
            load_alarm_r <= target_r;
          end else begin
            load_cnt_r   <= '0;
            load_time_r  <= 1'b0;
            load_alarm_r <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          load_time_r  <= 1'b0;
          load_alarm_r <= 1'b0;
          editing_r    <= 1'b0;
          cursor_r     <= CUR_H1;
          load_cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.H1         = h1_r;
  assign bus.H0         = h0_r;
  assign bus.M1         = m1_r;
  assign bus.M0         = m0_r;
  assign bus.load_time  = load_time_r;
  assign bus.load_alarm = load_alarm_r;
  assign bus.editing    = editing_r;
  assign bus.cursor     = cursor_r;
  assign bus.target     = target_r;

endmodule

// File: tb/tb_time_entry.sv
// ---------------------------------------------------------------------------
// tb_time_entry
// Directed self-checking bench for time_entry (DEBOUNCE_CYCLES=4,
// LOAD_CYCLES=8). Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_time_entry;

  localparam int BTN_MODE = 0;
  localparam int BTN_NEXT = 1;
  localparam int BTN_INC  = 2;
  localparam int BTN_SET  = 3;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  time_entry_if bus ();

  time_entry #(
    .DEBOUNCE_CYCLES (4),
    .LOAD_CYCLES     (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int b, input logic v);
    case (b)
      BTN_MODE: bus.btn_mode = v;
      BTN_NEXT: bus.btn_next = v;
      BTN_INC:  bus.btn_inc  = v;
      BTN_SET:  bus.btn_set  = v;
      default:  bus.btn_mode = bus.btn_mode;
    endcase
  endtask

  // Clean press: held long enough to be accepted, then released and settled.
  task automatic press(input int b, input int times);
    for (int k = 0; k < times; k++) begin
      drive(b, 1'b1);
      repeat (10) @(negedge clk);
      drive(b, 1'b0);
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic check_digits(input string tag, input logic [3:0] h1,
                              input logic [3:0] h0, input logic [3:0] m1,
                              input logic [3:0] m0);
    check({tag, "_H1"}, 32'(bus.H1), 32'(h1));
    check({tag, "_H0"}, 32'(bus.H0), 32'(h0));
    check({tag, "_M1"}, 32'(bus.M1), 32'(m1));
    check({tag, "_M0"}, 32'(bus.M0), 32'(m0));
  endtask

  // Press set and measure the strobe: width, exclusivity, digit stability.
  task automatic run_load(input string tag, input logic alarm,
                          input logic [3:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
    int n;
    int hi;
    logic strobe;
    drive(BTN_SET, 1'b1);
    n = 0;
    while ((bus.load_time | bus.load_alarm) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rise"}, 32'(bus.load_time | bus.load_alarm), 32'd1);
    check({tag, "_editing"}, 32'(bus.editing), 32'd0);
    check({tag, "_cursor"}, 32'(bus.cursor), 32'd0);
    hi = 0;
    strobe = alarm ? bus.load_alarm : bus.load_time;
    while (strobe === 1'b1 && hi < 20) begin
      check({tag, "_other"}, 32'(alarm ? bus.load_time : bus.load_alarm), 32'd0);
      check_digits({tag, "_hold"}, h1, h0, m1, m0);
      @(negedge clk);
      hi++;
      strobe = alarm ? bus.load_alarm : bus.load_time;
    end
    check({tag, "_width"}, 32'(hi), 32'd8);
    drive(BTN_SET, 1'b0);
    repeat (10) @(negedge clk);
    check({tag, "_idle_lt"}, 32'(bus.load_time), 32'd0);
    check({tag, "_idle_la"}, 32'(bus.load_alarm), 32'd0);
    check_digits({tag, "_after"}, h1, h0, m1, m0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_set  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check_digits("rst", 4'd0, 4'd0, 4'd0, 4'd0);
    check("rst_load_time", 32'(bus.load_time), 32'd0);
    check("rst_load_alarm", 32'(bus.load_alarm), 32'd0);
    check("rst_editing", 32'(bus.editing), 32'd0);
    check("rst_cursor", 32'(bus.cursor), 32'd0);
    check("rst_target", 32'(bus.target), 32'd0);

    // IDLE ignores inc
    press(BTN_INC, 1);
    check("idle_inc_H1", 32'(bus.H1), 32'd0);
    check("idle_inc_editing", 32'(bus.editing), 32'd0);

    // Enter edit, H1 wraps 1,2,0
    press(BTN_MODE, 1);
    check("mode_editing", 32'(bus.editing), 32'd1);
    check("mode_cursor", 32'(bus.cursor), 32'd0);
    check("mode_target", 32'(bus.target), 32'd0);
    press(BTN_INC, 1);
    check("h1_inc1", 32'(bus.H1), 32'd1);
    press(BTN_INC, 1);
    check("h1_inc2", 32'(bus.H1), 32'd2);
    press(BTN_INC, 1);
    check("h1_wrap", 32'(bus.H1), 32'd0);

    // H0 to 9, back to H1, H1 to 2 clamps H0 to 3, H0 then wraps 3->0
    press(BTN_NEXT, 1);
    check("cursor_h0", 32'(bus.cursor), 32'd1);
    press(BTN_INC, 9);
    check("h0_nine", 32'(bus.H0), 32'd9);
    press(BTN_NEXT, 3);
    check("cursor_wrap", 32'(bus.cursor), 32'd0);
    press(BTN_INC, 2);
    check("clamp_H1", 32'(bus.H1), 32'd2);
    check("clamp_H0", 32'(bus.H0), 32'd3);
    press(BTN_NEXT, 1);
    press(BTN_INC, 1);
    check("h0_wrap20", 32'(bus.H0), 32'd0);

    // Enter 23:59 and load time
    press(BTN_INC, 3);
    press(BTN_NEXT, 1);
    press(BTN_INC, 5);
    press(BTN_NEXT, 1);
    check("cursor_m0", 32'(bus.cursor), 32'd3);
    press(BTN_INC, 9);
    check_digits("t2359", 4'd2, 4'd3, 4'd5, 4'd9);
    run_load("ltime", 1'b0, 4'd2, 4'd3, 4'd5, 4'd9);
    check("ltime_target", 32'(bus.target), 32'd0);

    // mode twice -> alarm target, enter 07:30, load alarm
    press(BTN_MODE, 2);
    check("alarm_target", 32'(bus.target), 32'd1);
    check("alarm_editing", 32'(bus.editing), 32'd1);
    press(BTN_INC, 1);
    press(BTN_NEXT, 1);
    press(BTN_INC, 4);
    press(BTN_NEXT, 1);
    press(BTN_INC, 4);
    press(BTN_NEXT, 1);
    press(BTN_INC, 1);
    check_digits("a0730", 4'd0, 4'd7, 4'd3, 4'd0);
    run_load("lalarm", 1'b1, 4'd0, 4'd7, 4'd3, 4'd0);
    check("lalarm_target_kept", 32'(bus.target), 32'd1);

    // Re-entry clears target; 2-cycle glitch ignored, 6-cycle press counts once
    press(BTN_MODE, 1);
    check("reentry_target", 32'(bus.target), 32'd0);
    drive(BTN_INC, 1'b1);
    repeat (2) @(negedge clk);
    drive(BTN_INC, 1'b0);
    repeat (20) @(negedge clk);
    check("glitch_H1", 32'(bus.H1), 32'd0);
    drive(BTN_INC, 1'b1);
    repeat (6) @(negedge clk);
    drive(BTN_INC, 1'b0);
    repeat (20) @(negedge clk);
    check("press6_H1", 32'(bus.H1), 32'd1);

    // set and inc accepted together: set wins, H1 stays 1
    drive(BTN_SET, 1'b1);
    drive(BTN_INC, 1'b1);
    n = 0;
    while (bus.load_time !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("setinc_load", 32'(bus.load_time), 32'd1);
    check("setinc_H1", 32'(bus.H1), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_load_time", 32'(bus.load_time), 32'd0);
    check("midrst_load_alarm", 32'(bus.load_alarm), 32'd0);
    check_digits("midrst", 4'd0, 4'd0, 4'd0, 4'd0);
    check("midrst_editing", 32'(bus.editing), 32'd0);
    check("midrst_cursor", 32'(bus.cursor), 32'd0);
    check("midrst_target", 32'(bus.target), 32'd0);
    drive(BTN_SET, 1'b0);
    drive(BTN_INC, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_load_time", 32'(bus.load_time), 32'd0);
    check("post_rst_editing", 32'(bus.editing), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
